// File: rtl/comms_ctrl_mp.sv
// Multi-port comms controller: round-robin rx/event arbitration, config packet decode,
// regmap access, FIFO routing with full-timeout, tx ready/valid port and saturating stats.
module comms_ctrl_mp #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned GLOBAL_ID    = 255,
    parameter int unsigned READ_LATENCY = 5,
    parameter int unsigned FIFO_TIMEOUT = 15,
    parameter logic [31:0] MAGIC_NUMBER = 32'h89504E47
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS*(WIDTH-1)-1:0]   rx_data,
    input  logic [NUM_PORTS-1:0]             rx_data_flag,
    output logic [NUM_PORTS-1:0]             rx_ack,
    input  logic [WIDTH-2:0]                 event_data,
    input  logic                             event_valid,
    output logic                             event_ack,
    input  logic [7:0]                       chip_id,
    output logic [7:0]                       regmap_address,
    output logic [7:0]                       regmap_write_data,
    output logic                             write_regmap,
    output logic                             read_regmap,
    input  logic [7:0]                       regmap_read_data,
    output logic [WIDTH-2:0]                 fifo_data,
    output logic                             write_fifo_n,
    input  logic                             fifo_full,
    output logic [WIDTH-2:0]                 tx_config_data,
    output logic                             tx_config_valid,
    input  logic                             tx_config_ready,
    output logic [15:0]                      total_packets,
    output logic [15:0]                      bad_packets,
    output logic [15:0]                      dropped_packets,
    output logic                             comms_busy
);
    localparam int unsigned PW    = WIDTH - 1;
    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LAT_W = 4;
    localparam int unsigned TO_W  = 8;
    localparam logic [7:0]  GID   = 8'(GLOBAL_ID);
    localparam logic [1:0]  OP_INV  = 2'b00;
    localparam logic [1:0]  OP_DATA = 2'b01;
    localparam logic [1:0]  OP_WR   = 2'b10;

    typedef enum logic [2:0] {IDLE, CFG_WR, CFG_RD, TX_REPLY, TX_PASS, FIFO_WR, BAD} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, grant_idx, hi_idx, lo_idx;
    logic                 hi_any, rx_any;
    logic [PW-1:0]        rx_word, pkt_q, reply_word;
    logic [LAT_W-1:0]     lat_q;
    logic [TO_W-1:0]      wait_q;
    logic                 id_hit, magic_ok, pkt_global;
    logic [NUM_PORTS-1:0] rx_ack_q;
    logic                 event_ack_q, wr_q, rd_q, wfifo_n_q, tx_valid_q, busy_q;
    logic [7:0]           addr_q, wdata_q;
    logic [PW-1:0]        fifo_data_q, tx_data_q;
    logic [15:0]          total_q, bad_q, drop_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin: lowest flagged port at or above ptr, else lowest flagged port overall
    always_comb begin
        hi_any = 1'b0;
        rx_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rx_data_flag[i]) begin
                rx_any = 1'b1;
                lo_idx = PTR_W'(i);
                if (i >= int'(ptr_q)) begin
                    hi_any = 1'b1;
                    hi_idx = PTR_W'(i);
                end
            end
        end
        grant_idx = hi_any ? hi_idx : lo_idx;
        rx_word   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (PTR_W'(i) == grant_idx) rx_word = rx_data[i*PW +: PW];
        end
    end

    assign id_hit     = (rx_word[9:2] == chip_id) || (rx_word[9:2] == GID);
    assign magic_ok   = (rx_word[57:26] == MAGIC_NUMBER);
    assign pkt_global = (pkt_q[9:2] == GID);

    always_comb begin
        reply_word        = pkt_q;
        reply_word[25:18] = regmap_read_data;
        reply_word[9:2]   = chip_id;
        reply_word[62]    = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_any) begin
                    if (rx_word[1:0] == OP_INV)       state_d = BAD;
                    else if (rx_word[1:0] == OP_DATA) state_d = FIFO_WR;
                    else if (!magic_ok)               state_d = BAD;
                    else if (!id_hit)                 state_d = TX_PASS;
                    else if (rx_word[1:0] == OP_WR)   state_d = CFG_WR;
                    else                              state_d = CFG_RD;
                end else if (event_valid) begin
                    state_d = FIFO_WR;
                end
            end
            CFG_WR:   state_d = pkt_global ? TX_PASS : IDLE;
            CFG_RD:   if (lat_q == LAT_W'(READ_LATENCY - 1)) state_d = TX_REPLY;
            TX_REPLY: if (tx_config_ready) state_d = pkt_global ? TX_PASS : IDLE;
            TX_PASS:  if (tx_config_ready) state_d = IDLE;
            FIFO_WR:  if (!fifo_full || wait_q == TO_W'(FIFO_TIMEOUT - 1)) state_d = IDLE;
            BAD:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // All strobes and data outputs are registered; the action is prepared on entry to each state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            pkt_q       <= '0;
            lat_q       <= '0;
            wait_q      <= '0;
            rx_ack_q    <= '0;
            event_ack_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            fifo_data_q <= '0;
            wfifo_n_q   <= 1'b1;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            total_q     <= '0;
            bad_q       <= '0;
            drop_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            rx_ack_q    <= '0;
            event_ack_q <= 1'b0;
            wr_q        <= 1'b0;
            wfifo_n_q   <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (rx_any) begin
                        pkt_q    <= rx_word;
                        rx_ack_q <= NUM_PORTS'(1) << grant_idx;
                        ptr_q    <= (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PTR_W'(1);
                        if (state_d == CFG_WR) begin
                            wr_q    <= 1'b1;
                            addr_q  <= rx_word[17:10];
                            wdata_q <= rx_word[25:18];
                        end
                        if (state_d == CFG_RD) begin
                            rd_q   <= 1'b1;
                            addr_q <= rx_word[17:10];
                            lat_q  <= '0;
                        end
                        if (state_d == TX_PASS) begin
                            tx_data_q  <= rx_word;
                            tx_valid_q <= 1'b1;
                        end
                        if (state_d == FIFO_WR) begin
                            fifo_data_q <= rx_word;
                            wait_q      <= '0;
                        end
                    end else if (event_valid) begin
                        pkt_q       <= event_data;
                        event_ack_q <= 1'b1;
                        fifo_data_q <= event_data;
                        wait_q      <= '0;
                    end
                end
                CFG_WR: begin
                    if (state_d == TX_PASS) begin
                        tx_data_q  <= pkt_q;
                        tx_valid_q <= 1'b1;
                    end
                end
                CFG_RD: begin
                    lat_q <= lat_q + LAT_W'(1);
                    if (state_d == TX_REPLY) begin
                        rd_q       <= 1'b0;
                        tx_data_q  <= reply_word;
                        tx_valid_q <= 1'b1;
                    end
                end
                TX_REPLY: begin
                    if (tx_config_ready) begin
                        total_q <= sat_inc(total_q);
                        if (state_d == TX_PASS) tx_data_q  <= pkt_q;
                        else                    tx_valid_q <= 1'b0;
                    end
                end
                TX_PASS: begin
                    if (tx_config_ready) tx_valid_q <= 1'b0;
                end
                FIFO_WR: begin
                    if (!fifo_full) begin
                        wfifo_n_q <= 1'b0;
                        total_q   <= sat_inc(total_q);
                    end else if (state_d == IDLE) begin
                        drop_q <= sat_inc(drop_q);
                    end else begin
                        wait_q <= wait_q + TO_W'(1);
                    end
                end
                BAD:     bad_q <= sat_inc(bad_q);
                default: ;
            endcase
        end
    end

    assign rx_ack            = rx_ack_q;
    assign event_ack         = event_ack_q;
    assign regmap_address    = addr_q;
    assign regmap_write_data = wdata_q;
    assign write_regmap      = wr_q;
    assign read_regmap       = rd_q;
    assign fifo_data         = fifo_data_q;
    assign write_fifo_n      = wfifo_n_q;
    assign tx_config_data    = tx_data_q;
    assign tx_config_valid   = tx_valid_q;
    assign total_packets     = total_q;
    assign bad_packets       = bad_q;
    assign dropped_packets   = drop_q;
    assign comms_busy        = busy_q;

endmodule

// File: tb/tb_comms_ctrl_mp.sv
// Scoreboard bench for comms_ctrl_mp: stimulus pushes expected grants/strobes/words,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_comms_ctrl_mp;
    localparam int unsigned NP    = 4;
    localparam int unsigned PW    = 63;
    localparam logic [31:0] MAGIC = 32'h89504E47;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP*PW-1:0]  rx_data;
    logic [NP-1:0]     rx_data_flag;
    logic [NP-1:0]     rx_ack;
    logic [PW-1:0]     event_data;
    logic              event_valid;
    logic              event_ack;
    logic [7:0]        chip_id;
    logic [7:0]        regmap_address;
    logic [7:0]        regmap_write_data;
    logic              write_regmap;
    logic              read_regmap;
    logic [7:0]        regmap_read_data;
    logic [PW-1:0]     fifo_data;
    logic              write_fifo_n;
    logic              fifo_full;
    logic [PW-1:0]     tx_config_data;
    logic              tx_config_valid;
    logic              tx_config_ready;
    logic [15:0]       total_packets;
    logic [15:0]       bad_packets;
    logic [15:0]       dropped_packets;
    logic              comms_busy;

    comms_ctrl_mp #(
        .WIDTH(64), .NUM_PORTS(NP), .GLOBAL_ID(255), .READ_LATENCY(5),
        .FIFO_TIMEOUT(15), .MAGIC_NUMBER(MAGIC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_data_flag(rx_data_flag), .rx_ack(rx_ack),
        .event_data(event_data), .event_valid(event_valid), .event_ack(event_ack),
        .chip_id(chip_id),
        .regmap_address(regmap_address), .regmap_write_data(regmap_write_data),
        .write_regmap(write_regmap), .read_regmap(read_regmap),
        .regmap_read_data(regmap_read_data),
        .fifo_data(fifo_data), .write_fifo_n(write_fifo_n), .fifo_full(fifo_full),
        .tx_config_data(tx_config_data), .tx_config_valid(tx_config_valid),
        .tx_config_ready(tx_config_ready),
        .total_packets(total_packets), .bad_packets(bad_packets),
        .dropped_packets(dropped_packets), .comms_busy(comms_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int            exp_grant[$];
    logic [15:0]   exp_wr[$];
    logic [15:0]   exp_rd[$];
    logic [PW-1:0] exp_tx[$];
    logic [PW-1:0] exp_fifo[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    function automatic logic [PW-1:0] mk(input logic [1:0] op, input logic [7:0] id,
                                         input logic [7:0] addr, input logic [7:0] data,
                                         input logic [31:0] magic, input logic ds);
        logic [PW-1:0] w;
        w        = '0;
        w[1:0]   = op;
        w[9:2]   = id;
        w[17:10] = addr;
        w[25:18] = data;
        w[57:26] = magic;
        w[62]    = ds;
        return w;
    endfunction

    // Monitor: compares every DUT-presented event against the head of its queue
    initial begin
        int            rd_run;
        int            act_g;
        logic [7:0]    rd_addr;
        logic          stall;
        logic [PW-1:0] stall_data;
        rd_run     = 0;
        rd_addr    = '0;
        stall      = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                rd_run = 0;
                stall  = 1'b0;
            end else begin
                if (rx_ack != '0 || event_ack) begin
                    chk("ack_onehot", 64'($countones({event_ack, rx_ack})), 64'd1);
                    act_g = event_ack ? NP : 0;
                    for (int p = 0; p < NP; p++) if (rx_ack[p]) act_g = p;
                    if (exp_grant.size() == 0) unexpected("grant", 64'(act_g));
                    else chk("grant_order", 64'(act_g), 64'(exp_grant.pop_front()));
                end
                if (write_regmap) begin
                    if (exp_wr.size() == 0) unexpected("write_regmap", {regmap_address, regmap_write_data});
                    else chk("regmap_write", {regmap_address, regmap_write_data}, exp_wr.pop_front());
                end
                if (read_regmap) begin
                    if (rd_run == 0) rd_addr = regmap_address;
                    rd_run++;
                end else if (rd_run > 0) begin
                    if (exp_rd.size() == 0) unexpected("read_regmap", {8'(rd_run), rd_addr});
                    else chk("read_run_len_addr", {8'(rd_run), rd_addr}, exp_rd.pop_front());
                    rd_run = 0;
                end
                if (!write_fifo_n) begin
                    if (exp_fifo.size() == 0) unexpected("fifo_write", fifo_data);
                    else chk("fifo_word", fifo_data, exp_fifo.pop_front());
                end
                if (stall) begin
                    chk("tx_hold_valid", tx_config_valid, 1);
                    chk("tx_hold_data", tx_config_data, stall_data);
                end
                if (tx_config_valid && tx_config_ready) begin
                    if (exp_tx.size() == 0) unexpected("tx_word", tx_config_data);
                    else chk("tx_word", tx_config_data, exp_tx.pop_front());
                end
                stall      = tx_config_valid && !tx_config_ready;
                stall_data = tx_config_data;
            end
        end
    end

    task automatic send_rx(input int p, input logic [PW-1:0] w);
        int n;
        rx_data[p*PW +: PW] = w;
        rx_data_flag[p]     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_ack[p] && n < 50);
        rx_data_flag[p] = 1'b0;
        chk("rx_ack_seen", rx_ack[p], 1);
    endtask

    task automatic send_ev(input logic [PW-1:0] w);
        int n;
        event_data  = w;
        event_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!event_ack && n < 50);
        event_valid = 1'b0;
        chk("event_ack_seen", event_ack, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (comms_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, comms_busy, 0);
    endtask

    logic [PW-1:0] w3 [NP];
    logic [PW-1:0] w, ev;
    int            n, acks;

    initial begin
        reset_n          = 1'b0;
        rx_data          = '0;
        rx_data_flag     = '0;
        event_data       = '0;
        event_valid      = 1'b0;
        chip_id          = 8'h05;
        regmap_read_data = 8'h00;
        fifo_full        = 1'b0;
        tx_config_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_total", total_packets, 0);
        chk("rst_bad", bad_packets, 0);
        chk("rst_dropped", dropped_packets, 0);
        chk("rst_write_fifo_n", write_fifo_n, 1);
        chk("rst_busy", comms_busy, 0);
        chk("rst_tx_valid", tx_config_valid, 0);
        chk("rst_strobes", {write_regmap, read_regmap, event_ack, rx_ack}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: local config write from port 2
        exp_grant.push_back(2);
        exp_wr.push_back({8'h10, 8'hA5});
        send_rx(2, mk(2'b10, 8'h05, 8'h10, 8'hA5, MAGIC, 1'b0));
        repeat (3) @(negedge clk);
        wait_idle("t1_idle");
        chk("t1_total", total_packets, 0);

        // 2: broadcast config read from port 3, reply stalled 3 cycles, then pass-through
        regmap_read_data = 8'h3C;
        w = mk(2'b11, 8'hFF, 8'h20, 8'h00, MAGIC, 1'b0);
        exp_grant.push_back(3);
        exp_rd.push_back({8'd5, 8'h20});
        exp_tx.push_back(mk(2'b11, 8'h05, 8'h20, 8'h3C, MAGIC, 1'b1));
        exp_tx.push_back(w);
        send_rx(3, w);
        n = 0;
        while (!tx_config_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t2_reply_valid", tx_config_valid, 1);
        repeat (3) @(negedge clk);
        tx_config_ready = 1'b1;
        n = 0;
        while (tx_config_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t2_tx_done", tx_config_valid, 0);
        tx_config_ready = 1'b0;
        wait_idle("t2_idle");
        chk("t2_total", total_packets, 1);

        // 3: all ports held flagged plus a pending event
        for (int p = 0; p < NP; p++) begin
            w3[p] = mk(2'b01, 8'(8'h40 + p), 8'(p), 8'(3 * p + 1), 32'h0, 1'b0);
            rx_data[p*PW +: PW] = w3[p];
        end
        for (int i = 0; i < 5; i++) begin
            exp_grant.push_back(i % NP);
            exp_fifo.push_back(w3[i % NP]);
        end
        ev = mk(2'b01, 8'hE0, 8'hE1, 8'hE2, 32'h12345678, 1'b0);
        exp_grant.push_back(NP);
        exp_fifo.push_back(ev);
        event_data   = ev;
        event_valid  = 1'b1;
        rx_data_flag = '1;
        acks = 0;
        n    = 0;
        while (acks < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (rx_ack != '0) acks++;
        end
        rx_data_flag = '0;
        chk("t3_rx_grants", 64'(acks), 5);
        n = 0;
        while (!event_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        event_valid = 1'b0;
        chk("t3_event_ack", event_ack, 1);
        repeat (2) @(negedge clk);
        wait_idle("t3_idle");
        chk("t3_total", total_packets, 7);

        // 4a: FIFO full throughout -> drop after 15 full cycles
        fifo_full = 1'b1;
        exp_grant.push_back(NP);
        send_ev(mk(2'b01, 8'h11, 8'h22, 8'h33, 32'h0, 1'b0));
        repeat (14) @(negedge clk);
        chk("t4_dropped_cycle15", dropped_packets, 0);
        chk("t4_busy_cycle15", comms_busy, 1);
        @(negedge clk);
        chk("t4_dropped", dropped_packets, 1);
        chk("t4_idle_after_drop", comms_busy, 0);

        // 4b: FIFO full released at cycle 7 -> exactly one write
        ev = mk(2'b01, 8'h44, 8'h55, 8'h66, 32'hCAFEF00D, 1'b1);
        exp_grant.push_back(NP);
        exp_fifo.push_back(ev);
        send_ev(ev);
        repeat (6) @(negedge clk);
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        wait_idle("t4b_idle");
        chk("t4b_total", total_packets, 8);
        chk("t4b_dropped", dropped_packets, 1);

        // 5: malformed packets and counter saturation
        exp_grant.push_back(0);
        send_rx(0, mk(2'b00, 8'h05, 8'h10, 8'hA5, MAGIC, 1'b0));
        exp_grant.push_back(1);
        send_rx(1, mk(2'b10, 8'h05, 8'h10, 8'hA5, 32'h0, 1'b0));
        repeat (2) @(negedge clk);
        wait_idle("t5_idle");
        chk("t5_bad", bad_packets, 2);
        force dut.bad_q = 16'hFFFF;
        @(negedge clk);
        release dut.bad_q;
        @(negedge clk);
        chk("t5_bad_forced", bad_packets, 16'hFFFF);
        exp_grant.push_back(2);
        send_rx(2, mk(2'b00, 8'h00, 8'h00, 8'h00, 32'h0, 1'b0));
        repeat (3) @(negedge clk);
        chk("t5_bad_saturated", bad_packets, 16'hFFFF);

        // 6: reset during the third read cycle of a local config read from port 1
        exp_grant.push_back(1);
        send_rx(1, mk(2'b11, 8'h05, 8'h30, 8'h00, MAGIC, 1'b0));
        repeat (2) @(negedge clk);
        chk("t6_reading", read_regmap, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_read", read_regmap, 0);
        chk("t6_rst_write_fifo_n", write_fifo_n, 1);
        chk("t6_rst_busy", comms_busy, 0);
        chk("t6_rst_tx_valid", tx_config_valid, 0);
        chk("t6_rst_addr", regmap_address, 0);
        chk("t6_rst_counts", {total_packets, bad_packets, dropped_packets}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_rst", comms_busy, 0);
        w3[0] = mk(2'b01, 8'h70, 8'h71, 8'h72, 32'h0, 1'b0);
        w3[3] = mk(2'b01, 8'h73, 8'h74, 8'h75, 32'h0, 1'b0);
        rx_data[0*PW +: PW] = w3[0];
        rx_data[3*PW +: PW] = w3[3];
        exp_grant.push_back(0);
        exp_fifo.push_back(w3[0]);
        exp_grant.push_back(3);
        exp_fifo.push_back(w3[3]);
        rx_data_flag[0] = 1'b1;
        rx_data_flag[3] = 1'b1;
        n = 0;
        while (rx_data_flag != '0 && n < 50) begin
            @(negedge clk);
            n++;
            rx_data_flag = rx_data_flag & ~rx_ack;
        end
        chk("t6_flags_served", rx_data_flag, 0);
        repeat (2) @(negedge clk);
        wait_idle("t6_idle");
        chk("t6_total", total_packets, 2);

        repeat (3) @(negedge clk);
        chk("q_grant_empty", 64'(exp_grant.size()), 0);
        chk("q_wr_empty", 64'(exp_wr.size()), 0);
        chk("q_rd_empty", 64'(exp_rd.size()), 0);
        chk("q_tx_empty", 64'(exp_tx.size()), 0);
        chk("q_fifo_empty", 64'(exp_fifo.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/comms_ctrl_mp.md
Name: comms_ctrl_mp

Overview:
Multi-port successor to the single-channel comms controller.
- Round-robin arbitrates NUM_PORTS rx UART channels plus the local event router.
- Decodes config write/read packets against chip_id or GLOBAL_ID, with read latency set by parameter.
- Routes data packets to the event FIFO under backpressure with a timeout, and config traffic and read replies to a ready/valid tx port.
- Keeps saturating packet statistics.

Parameters:
WIDTH, 64, packet width including parity; payload is WIDTH-1 bits; minimum 64.
NUM_PORTS, 4, number of rx channels; range 1..8.
GLOBAL_ID, 255, broadcast chip ID.
READ_LATENCY, 5, cycles read_regmap is held before regmap_read_data is sampled; range 1..15.
FIFO_TIMEOUT, 15, cycles to wait on fifo_full before dropping; range 1..255.
MAGIC_NUMBER, 32'h89504E47, required value of payload [57:26] for config packets.

Ports:
clk  in  1  primary clock
reset_n  in  1  asynchronous reset, active low
rx_data  in  NUM_PORTS*(WIDTH-1)  packed rx payloads; port p occupies [p*(WIDTH-1) +: WIDTH-1]
rx_data_flag  in  NUM_PORTS  port p holds a packet
rx_ack  out  NUM_PORTS  one-cycle pulse; port p packet consumed
event_data  in  WIDTH-1  event payload from the router
event_valid  in  1  router event pending
event_ack  out  1  one-cycle pulse; event consumed
chip_id  in  8  unique chip ID
regmap_address  out  8  register address
regmap_write_data  out  8  register write data
write_regmap  out  1  register write strobe
read_regmap  out  1  register read enable
regmap_read_data  in  8  register read data
fifo_data  out  WIDTH-1  word to the FIFO
write_fifo_n  out  1  FIFO write strobe, active low
fifo_full  in  1  FIFO cannot accept a word
tx_config_data  out  WIDTH-1  config or reply word to the tx path
tx_config_valid  out  1  tx word valid
tx_config_ready  in  1  tx path accepts the word
total_packets  out  16  words written to the FIFO plus replies sent; saturating
bad_packets  out  16  malformed packets; saturating
dropped_packets  out  16  FIFO timeouts; saturating
comms_busy  out  1  high in any state except IDLE

Behaviour:
Reset:
- All outputs 0, except write_fifo_n = 1.
- Round-robin pointer = 0; FSM in IDLE.
- Reset takes effect mid-operation: the in-flight packet is lost and no strobe completes.

Packet fields (payload bits): op [1:0], with 00 = invalid, 01 = data, 10 = config write, 11 = config read; id [9:2]; addr [17:10]; data [25:18]; magic [57:26]; downstream flag [62].

Arbitration (IDLE only):
- Grant the lowest port index >= ptr with its flag set, wrapping around.
- On a grant: capture the packet into pkt_q, pulse rx_ack[g], set ptr = (g+1) mod NUM_PORTS.
- Any rx flag has priority over event_valid.
- With no rx flag and event_valid high: capture event_data, pulse event_ack, go to FIFO_WR.

Decode of the captured packet (selects the next state):
- op = 00, or config op with magic != MAGIC_NUMBER -> BAD.
- Config write with id == chip_id or GLOBAL_ID -> CFG_WR.
- Config read with id == chip_id or GLOBAL_ID -> CFG_RD.
- Other config op -> TX_PASS.
- op = 01 -> FIFO_WR.

States:
- CFG_WR: one-cycle write_regmap with addr/data; then TX_PASS if id == GLOBAL_ID, else IDLE.
- CFG_RD:
  - read_regmap = 1 and regmap_address = addr for exactly READ_LATENCY cycles.
  - In the last cycle, form the reply: pkt_q with [25:18] = regmap_read_data, [9:2] = chip_id, [62] = 1.
  - Then go to TX_REPLY.
- TX_REPLY: tx_config_valid = 1 with the reply, held stable until a cycle with tx_config_ready = 1. Then total_packets++ and go to TX_PASS if the original id == GLOBAL_ID, else IDLE.
- TX_PASS: present pkt_q unmodified with the same handshake, then IDLE. Not counted.
- FIFO_WR: fifo_data = word.
  - If fifo_full = 0: write_fifo_n low for one cycle, total_packets++, then IDLE.
  - Otherwise increment the wait counter; at FIFO_TIMEOUT full cycles, dropped_packets++ and go to IDLE without a write.
- BAD: bad_packets++, then IDLE.

Timing and general rules:
- Minimum latency is 1 capture cycle + 1 action cycle.
- Exactly one packet is accepted per return to IDLE.
- All strobes are registered.
- Counters hold at 16'hFFFF (no wrap).
- rx_ack and event_ack are never asserted together.

Test Plan:
1. Port 2 sends config write, id = chip_id = 8'h05, addr 8'h10, data 8'hA5, valid magic -> rx_ack[2] pulse, one write_regmap cycle with 8'h10/8'hA5, no tx traffic, back to IDLE.
2. Broadcast config read, id 8'hFF, READ_LATENCY = 5, regmap_read_data = 8'h3C -> read_regmap high for exactly 5 cycles. Then a reply with [25:18] = 8'h3C, [9:2] = 8'h05, [62] = 1, held 3 cycles while tx_config_ready = 0. Then the original packet is passed unchanged; total_packets = 1.
3. All 4 ports flagged simultaneously and held -> grants in order 0, 1, 2, 3, 0; event_valid is served only once all flags drop.
4. Event with fifo_full held high -> no write_fifo_n pulse, dropped_packets = 1 after 15 full cycles. Repeat with fifo_full released at cycle 7 -> exactly one write, total_packets increments.
5. op = 00 packet, then config write with magic 32'h0 -> bad_packets = 2, no regmap strobes. Force bad_packets to 16'hFFFF, send another bad packet -> it stays 16'hFFFF.
6. Assert reset_n low during CFG_RD cycle 3 -> all outputs return to reset values immediately, write_fifo_n = 1, and after release the FSM is IDLE with ptr = 0.
